// File: rtl/audio_pkg.sv
// Shared state encoding and width helpers for the audio envelope output stage.
package audio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECAY   = 3'd1,
    ST_SUSTAIN = 3'd2,
    ST_FADE    = 3'd3,
    ST_MUTED   = 3'd4
  } env_state_e;

  localparam int unsigned PWM_BITS_DFLT = 8;

  // Mid-scale PWM code: 50% duty, the silent operating point.
  function automatic int unsigned mid_of(input int unsigned bits);
    return 32'd1 << (bits - 1);
  endfunction

  function automatic int unsigned pre_width(input int unsigned div_a, input int unsigned div_b);
    int unsigned m;
    m = (div_a > div_b) ? div_a : div_b;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/audio_envelope_out_pwm_dac.sv
// Mid-centred PWM DAC: free-running counter compared against a duty built
// from the envelope half-amplitude around mid-scale.
module pwm_dac
  import audio_pkg::*;
#(
  parameter int unsigned PWM_BITS = PWM_BITS_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tone_i,
  input  logic [PWM_BITS-1:0] env_i,
  output logic                pwm_o
);

  localparam logic [PWM_BITS-1:0] MID = PWM_BITS'(mid_of(PWM_BITS));

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] half;
  logic [PWM_BITS-1:0] duty;
  logic                pwm_q, pwm_d;

  // env >> 1 keeps MID+h <= 2^W-1 and MID-h >= 1, so no wrap is possible.
  assign half  = env_i >> 1;
  assign duty  = tone_i ? (MID + half) : (MID - half);
  assign cnt_d = cnt_q + PWM_BITS'(1);
  assign pwm_d = (cnt_q < duty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/audio_envelope_out.sv
// Speaker output stage: per-note decay envelope, mute fade and PWM drive.
//   state   | meaning
//   IDLE    | no note yet, env 0, amplifier off
//   DECAY   | env stepping down toward the sustain floor
//   SUSTAIN | env held (at floor, or at a note level below it)
//   FADE    | muting: env stepping down to 0
//   MUTED   | silent, amplifier off, waiting for mute release
module audio_envelope_out
  import audio_pkg::*;
#(
  parameter int unsigned PWM_BITS    = PWM_BITS_DFLT,
  parameter int unsigned DECAY_DIV   = 65536,
  parameter int unsigned DECAY_STEP  = 4,
  parameter int unsigned SUSTAIN_LVL = 64,
  parameter int unsigned FADE_DIV    = 16384
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tone_in,
  input  logic                note_start,
  input  logic [PWM_BITS-1:0] volume,
  input  logic                mute,
  output logic                pwm_out,
  output logic                amp_en,
  output logic [PWM_BITS-1:0] level
);

  localparam int unsigned         PRE_W      = pre_width(DECAY_DIV, FADE_DIV);
  localparam logic [PRE_W-1:0]    DECAY_LAST = PRE_W'(DECAY_DIV - 1);
  localparam logic [PRE_W-1:0]    FADE_LAST  = PRE_W'(FADE_DIV - 1);
  localparam logic [PWM_BITS-1:0] FLOOR      = PWM_BITS'(SUSTAIN_LVL);
  localparam logic [PWM_BITS-1:0] STEP       = PWM_BITS'(DECAY_STEP);

  env_state_e          state_q, state_d;
  logic [PWM_BITS-1:0] env_q, env_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                tone_q;
  logic                amp_q, amp_d;
  logic [PWM_BITS-1:0] decay_nx;
  logic [PWM_BITS-1:0] fade_nx;

  // In DECAY env is always above FLOOR, so env-FLOOR cannot underflow.
  assign decay_nx = ((env_q - FLOOR) > STEP) ? (env_q - STEP) : FLOOR;
  assign fade_nx  = (env_q > STEP) ? (env_q - STEP) : '0;

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    pre_d   = pre_q;
    unique case (state_q)
      ST_IDLE: begin
        env_d = '0;
        pre_d = '0;
        if (mute) begin
          state_d = ST_MUTED;
        end else if (note_start) begin
          env_d   = volume;
          state_d = (volume > FLOOR) ? ST_DECAY : ST_SUSTAIN;
        end
      end
      ST_DECAY, ST_SUSTAIN: begin
        if (mute) begin
          state_d = ST_FADE;
          pre_d   = '0;
        end else if (note_start) begin
          env_d   = volume;
          pre_d   = '0;
          state_d = (volume > FLOOR) ? ST_DECAY : ST_SUSTAIN;
        end else if (state_q == ST_DECAY) begin
          if (pre_q == DECAY_LAST) begin
            pre_d = '0;
            env_d = decay_nx;
            if (decay_nx == FLOOR) state_d = ST_SUSTAIN;
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
      end
      ST_FADE: begin
        if (env_q == '0) begin
          state_d = ST_MUTED;
          pre_d   = '0;
        end else if (pre_q == FADE_LAST) begin
          pre_d = '0;
          env_d = fade_nx;
          if (fade_nx == '0) state_d = ST_MUTED;
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      ST_MUTED: begin
        env_d = '0;
        pre_d = '0;
        if (!mute) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        env_d   = '0;
        pre_d   = '0;
      end
    endcase
    amp_d = (state_d == ST_DECAY) || (state_d == ST_SUSTAIN) || (state_d == ST_FADE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      env_q   <= '0;
      pre_q   <= '0;
      tone_q  <= 1'b0;
      amp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      pre_q   <= pre_d;
      tone_q  <= tone_in;
      amp_q   <= amp_d;
    end
  end

  pwm_dac #(.PWM_BITS(PWM_BITS)) u_pwm_dac (
    .clk   (clk),
    .rst   (rst),
    .tone_i(tone_q),
    .env_i (env_q),
    .pwm_o (pwm_out)
  );

  assign amp_en = amp_q;
  assign level  = env_q;

endmodule

// File: tb/tb_audio_envelope_out.sv
// Scoreboard bench for audio_envelope_out: a behavioural envelope model pushes
// the expected outputs every clock, a monitor pops and compares them.
module tb_audio_envelope_out;

  localparam int DDIV  = 4;
  localparam int FDIV  = 2;
  localparam int STEP  = 16;
  localparam int FLOOR = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tone_in = 1'b0;
  logic       note_start = 1'b0;
  logic       mute = 1'b0;
  logic [7:0] volume = 8'd0;
  logic       pwm_out;
  logic       amp_en;
  logic [7:0] level;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  audio_envelope_out #(
    .PWM_BITS   (8),
    .DECAY_DIV  (DDIV),
    .DECAY_STEP (STEP),
    .SUSTAIN_LVL(FLOOR),
    .FADE_DIV   (FDIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tone_in   (tone_in),
    .note_start(note_start),
    .volume    (volume),
    .mute      (mute),
    .pwm_out   (pwm_out),
    .amp_en    (amp_en),
    .level     (level)
  );

  // Reference model: envelope level plus a few flags describing what the
  // speaker should be doing, advanced once per clock.
  int         m_env = 0;
  int         m_tick = 0;
  int         m_cnt = 0;
  bit         m_tone = 0;
  bit         m_on = 0;
  bit         m_decaying = 0;
  bit         m_fading = 0;
  bit         m_silent = 0;
  bit         m_pwm;
  bit         m_amp;
  logic [9:0] sb_q[$];
  logic [9:0] sb_exp;

  function automatic int duty_of(input int env, input bit tone);
    return tone ? 128 + env / 2 : 128 - env / 2;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_env = 0; m_tick = 0; m_cnt = 0; m_tone = 0;
      m_on = 0; m_decaying = 0; m_fading = 0; m_silent = 0;
      sb_q.delete();
    end else begin
      m_pwm  = (m_cnt < duty_of(m_env, m_tone));
      m_cnt  = (m_cnt + 1) % 256;
      m_tone = tone_in;
      if (m_fading) begin
        if (m_env == 0) begin
          m_fading = 0; m_silent = 1;
        end else begin
          m_tick++;
          if (m_tick == FDIV) begin
            m_tick = 0;
            m_env  = (m_env > STEP) ? m_env - STEP : 0;
            if (m_env == 0) begin m_fading = 0; m_silent = 1; end
          end
        end
      end else if (m_silent) begin
        if (!mute) m_silent = 0;
      end else if (mute) begin
        if (m_on) begin m_on = 0; m_fading = 1; m_tick = 0; end
        else m_silent = 1;
      end else if (note_start) begin
        m_env = int'(volume); m_tick = 0; m_on = 1;
        m_decaying = (int'(volume) > FLOOR);
      end else if (m_on && m_decaying) begin
        m_tick++;
        if (m_tick == DDIV) begin
          m_tick = 0;
          m_env  = (m_env - STEP > FLOOR) ? m_env - STEP : FLOOR;
          if (m_env == FLOOR) m_decaying = 0;
        end
      end
      m_amp = m_on || m_fading;
      sb_q.push_back({m_amp, m_pwm, 8'(m_env)});
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: no expected entry at t=%0t", $time);
      end else begin
        sb_exp = sb_q.pop_front();
        if ({amp_en, pwm_out, level} !== sb_exp) begin
          n_fail++;
          $display("FAIL scoreboard t=%0t: got amp=%0b pwm=%0b level=%0d, expected amp=%0b pwm=%0b level=%0d",
                   $time, amp_en, pwm_out, level, sb_exp[9], sb_exp[8], sb_exp[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic note(input int v);
    @(negedge clk);
    note_start = 1'b1;
    volume     = 8'(v);
    @(negedge clk);
    note_start = 1'b0;
  endtask

  task automatic wait_level(input int target, input string name);
    for (int i = 0; i < 60 && int'(level) != target; i++) @(negedge clk);
    check(name, int'(level), target);
  endtask

  int hi_cnt;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_level", int'(level), 0);
    check("rst_amp", int'(amp_en), 0);
    check("rst_pwm", int'(pwm_out), 0);
    rst = 1'b0;

    hi_cnt = 0;
    repeat (256) begin
      @(negedge clk);
      hi_cnt += int'(pwm_out);
      tone_in = ~tone_in;
    end
    check("idle_duty", hi_cnt, 128);
    check("idle_amp", int'(amp_en), 0);
    tone_in = 1'b1;

    note(200);
    check("attack_200", int'(level), 200);
    check("attack_amp", int'(amp_en), 1);
    repeat (60) @(negedge clk);
    check("sustain_floor", int'(level), 64);

    note(200);
    wait_level(136, "reach_136");
    note(40);
    check("retrig_40", int'(level), 40);
    repeat (20) @(negedge clk);
    check("retrig_hold", int'(level), 40);

    note(64);
    check("at_64", int'(level), 64);
    @(negedge clk); mute = 1'b1;
    repeat (12) @(negedge clk);
    check("faded_level", int'(level), 0);
    check("faded_amp", int'(amp_en), 0);
    note(150);
    check("muted_ignore", int'(level), 0);

    mute = 1'b0;
    repeat (2) @(negedge clk);
    note(64);
    @(negedge clk);
    mute = 1'b1; note_start = 1'b1; volume = 8'd250;
    @(negedge clk);
    note_start = 1'b0;
    check("mute_wins_level", int'(level), 64);
    check("mute_wins_amp", int'(amp_en), 1);
    repeat (12) @(negedge clk);
    mute = 1'b0;
    repeat (3) @(negedge clk);
    note(100);
    check("after_unmute", int'(level), 100);

    note(200);
    wait_level(120, "reach_120");
    rst = 1'b1;
    #1;
    check("rst_mid_level", int'(level), 0);
    check("rst_mid_amp", int'(amp_en), 0);
    check("rst_mid_pwm", int'(pwm_out), 0);
    @(negedge clk);
    rst = 1'b0;

    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) tone_in = ~tone_in;
      note_start = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 7))
        0:       volume = 8'd0;
        1:       volume = 8'd64;
        2:       volume = 8'd65;
        3:       volume = 8'd255;
        default: volume = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 39) == 0) mute = ~mute;
      rst = ($urandom_range(0, 599) == 0);
    end
    rst = 1'b0;
    note_start = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
